// File: rtl/nn_inference_ctrl_pkg.sv
// Shared state encoding and default sizing for the NN inference controller.
package nn_inference_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_NN,
        SETTLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_NUM_INPUTS     = 784;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_NUM_OUTPUTS    = 10;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_SETTLE_CYCLES  = 1;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_CONTINUOUS     = 0;

endpackage

// File: rtl/nn_inference_ctrl_if.sv
// Controller <-> NeuralNetwork link: frame out, reset/run strobes, argmax result back.
interface nn_inference_ctrl_if
    import nn_inference_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS
);
    localparam int IDX_W = $clog2(NUM_OUTPUTS);

    logic [NUM_INPUTS*DATA_WIDTH-1:0] nn_in;
    logic                             nn_reset;
    logic                             nn_valid;
    logic                             max_valid;
    logic [IDX_W-1:0]                 max_index;
    logic [DATA_WIDTH-1:0]            max_value;

    modport master (
        output nn_in, nn_reset, nn_valid,
        input  max_valid, max_index, max_value
    );

    modport slave (
        input  nn_in, nn_reset, nn_valid,
        output max_valid, max_index, max_value
    );

endinterface

// File: rtl/nn_inference_ctrl_serial_frame_rx.sv
// Serial front end: synchronises the async link, shifts bits LSB-first and flags frame completion.
module serial_frame_rx #(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  serial_clk,
    input  logic                  serial_data,
    input  logic                  frame_sync,
    output logic [FRAME_BITS-1:0] shadow,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync, fs_sync;
    logic                   clk_last, fs_last;
    logic                   clk_rise, fs_rise;
    logic [CNT_W-1:0]       bit_cnt;

    assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_last;
    assign fs_rise  = fs_sync[SYNC_STAGES-1] & ~fs_last;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            fs_sync    <= '0;
            clk_last   <= 1'b0;
            fs_last    <= 1'b0;
            bit_cnt    <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], serial_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], serial_data};
            fs_sync    <= {fs_sync[SYNC_STAGES-2:0], frame_sync};
            clk_last   <= clk_sync[SYNC_STAGES-1];
            fs_last    <= fs_sync[SYNC_STAGES-1];
            frame_done <= 1'b0;
            // A frame_sync edge outranks a coincident bit: no shift, no count.
            if (fs_rise) begin
                bit_cnt <= '0;
            end else if (clk_rise) begin
                shadow <= {data_sync[SYNC_STAGES-1], shadow[FRAME_BITS-1:1]};
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nn_inference_ctrl.sv
// Inference sequencer: loads received frames into the network, runs it and latches the argmax.
//
// state    | meaning
// IDLE     | waiting for frame_ready, start, or continuous rerun
// RESET_NN | nn_reset asserted for one cycle
// SETTLE   | SETTLE_CYCLES quiet cycles before enabling the network
// RUN      | nn_valid high until max_valid or timeout
// DONE     | result_valid pulse, run_count advanced
module nn_inference_ctrl
    import nn_inference_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS     = DEF_NUM_INPUTS,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_OUTPUTS    = DEF_NUM_OUTPUTS,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CONTINUOUS     = DEF_CONTINUOUS,
    localparam int IDX_W         = $clog2(NUM_OUTPUTS)
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   serial_clk,
    input  logic                   serial_data,
    input  logic                   frame_sync,
    input  logic                   start,
    input  logic                   clear_err,
    nn_inference_ctrl_if.master    nn_bus,
    output logic [IDX_W-1:0]       result_index,
    output logic [DATA_WIDTH-1:0]  result_value,
    output logic                   result_valid,
    output logic                   frame_ready,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun_err,
    output logic [7:0]             run_count
);
    localparam int FRAME_BITS = NUM_INPUTS * DATA_WIDTH;
    localparam int TMR_MAX    = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    state_t                state;
    logic [TMR_W-1:0]      timer;
    logic [FRAME_BITS-1:0] shadow;
    logic                  frame_done;

    serial_frame_rx #(
        .FRAME_BITS  (FRAME_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .serial_clk  (serial_clk),
        .serial_data (serial_data),
        .frame_sync  (frame_sync),
        .shadow      (shadow),
        .frame_done  (frame_done)
    );

    assign busy            = (state != IDLE);
    assign nn_bus.nn_valid = (state == RUN) && !nn_bus.max_valid;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            nn_bus.nn_in    <= '0;
            nn_bus.nn_reset <= 1'b0;
            result_index    <= '0;
            result_value    <= '0;
            result_valid    <= 1'b0;
            frame_ready     <= 1'b0;
            timeout_err     <= 1'b0;
            overrun_err     <= 1'b0;
            run_count       <= '0;
        end else begin
            frame_ready     <= 1'b0;
            result_valid    <= 1'b0;
            nn_bus.nn_reset <= 1'b0;
            // Clears come first so any set later in this block wins.
            if (clear_err) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (frame_done) begin
                if (state == IDLE) begin
                    nn_bus.nn_in <= shadow;
                    frame_ready  <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (CONTINUOUS != 0 || frame_ready || start) begin
                        state           <= RESET_NN;
                        nn_bus.nn_reset <= 1'b1;
                    end
                end
                RESET_NN: begin
                    state <= SETTLE;
                    timer <= TMR_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (timer == '0) begin
                        state <= RUN;
                        timer <= TMR_W'(TIMEOUT_CYCLES - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RUN: begin
                    if (nn_bus.max_valid) begin
                        result_index <= nn_bus.max_index;
                        result_value <= nn_bus.max_value;
                        result_valid <= 1'b1;
                        run_count    <= run_count + 8'd1;
                        state        <= DONE;
                    end else if (timer == '0) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
